sfx_mixer: RTL and testbench

SFX_MIXER -- requirements
Module: sfx_mixer

---
 rtl/sfx_mixer.sv | 153 +++++++++++++++
 tb/tb_sfx_mixer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_mixer.sv
// Square-wave sound-effect generator mixed over a background stereo stream,
// with output ducking, saturation and a write handshake towards Audio_Controller.
module sfx_mixer #(
  parameter int                 TICK_DIV = 50000,
  parameter logic signed [9:0]  SFX_AMP  = 10'sd200,
  parameter int                 HP_MOVE  = 56818,
  parameter int                 HP_PUSH  = 37879,
  parameter int                 HP_WIN   = 25000,
  parameter int                 HP_FAIL  = 113636,
  parameter int                 MS_MOVE  = 40,
  parameter int                 MS_PUSH  = 80,
  parameter int                 MS_WIN   = 400,
  parameter int                 MS_FAIL  = 200
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic signed [9:0]  bgm_left,
  input  logic signed [9:0]  bgm_right,
  input  logic               bgm_valid,
  input  logic               sfx_trigger,
  input  logic [1:0]         sfx_id,
  input  logic               audio_out_allowed,
  output logic [31:0]        left_channel_audio_out,
  output logic [31:0]        right_channel_audio_out,
  output logic               write_audio_out,
  output logic               sfx_busy
);

  typedef enum logic [1:0] {IDLE, TONE, TONE_HI} state_t;

  state_t              state, state_nxt;
  logic [1:0]          id_q;
  logic [31:0]         tick_cnt, ms_cnt, tone_cnt;
  logic [31:0]         half_period, duration, ms_inc;
  logic                tick_wrap, phase, pending;
  logic signed [9:0]   sfx_val;
  logic [9:0]          mix_left, mix_right;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    half_period = 32'(HP_MOVE);
    duration    = 32'(MS_MOVE);
    case (id_q)
      2'd1: begin half_period = 32'(HP_PUSH); duration = 32'(MS_PUSH); end
      2'd2: begin half_period = 32'(HP_WIN);  duration = 32'(MS_WIN);  end
      2'd3: begin half_period = 32'(HP_FAIL); duration = 32'(MS_FAIL); end
      default: ;
    endcase
    if (state == TONE_HI) half_period = half_period >> 1;
  end

  assign tick_wrap = (tick_cnt == 32'(TICK_DIV - 1));
  assign ms_inc    = ms_cnt + 32'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sfx_trigger) state_nxt = TONE;
      TONE: begin
        if (sfx_trigger) state_nxt = TONE;
        else if (tick_wrap && ms_inc == duration) state_nxt = IDLE;
        else if (tick_wrap && id_q == 2'd2 && ms_inc == (duration >> 1)) state_nxt = TONE_HI;
      end
      TONE_HI: begin
        if (sfx_trigger) state_nxt = TONE;
        else if (tick_wrap && ms_inc == duration) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: asynchronous reset in the sensitivity list; sequential state uses <= only.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      id_q     <= 2'd0;
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (sfx_trigger) begin
      id_q     <= sfx_id;
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_inc;
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
      end
      // >= so an in-flight count above the halved period wraps at once.
      if (tone_cnt >= half_period - 32'd1) begin
        tone_cnt <= '0;
        phase    <= ~phase;
      end else begin
        tone_cnt <= tone_cnt + 32'd1;
      end
    end
  end

  assign sfx_busy = (state != IDLE);

  always_comb begin
    sfx_val = '0;
    if (state != IDLE) sfx_val = phase ? SFX_AMP : -SFX_AMP;
  end

  function automatic logic [9:0] mix_ch(input logic signed [9:0] bgm,
                                        input logic              duck,
                                        input logic signed [9:0] sfx);
    logic signed [11:0] b, s, sum;
    b = {{2{bgm[9]}}, bgm};
    s = {{2{sfx[9]}}, sfx};
    if (duck) b = b >>> 1;
    sum = b + s;
    if (sum > 12'sd511)       return 10'h1FF;
    else if (sum < -12'sd512) return 10'h200;
    else                      return sum[9:0];
  endfunction

  assign mix_left  = mix_ch(bgm_left,  sfx_busy, sfx_val);
  assign mix_right = mix_ch(bgm_right, sfx_busy, sfx_val);

  // A new sample overrides an unsent one; a strobe in the same cycle still sends the old one.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      pending                 <= 1'b0;
    end else if (bgm_valid) begin
      left_channel_audio_out  <= {mix_left,  22'd0};
      right_channel_audio_out <= {mix_right, 22'd0};
      pending                 <= 1'b1;
    end else if (write_audio_out) begin
      pending <= 1'b0;
    end
  end

  assign write_audio_out = pending & audio_out_allowed;

endmodule

// File: tb/tb_sfx_mixer.sv
// Directed bench for sfx_mixer with shortened timing; a second instance with a
// larger amplitude exercises output saturation.
module tb_sfx_mixer;

  localparam int TICK = 10;

  logic               CLOCK_50 = 1'b0;
  logic               resetn = 1'b0;
  logic signed [9:0]  bgm_left = '0, bgm_right = '0;
  logic               bgm_valid = 1'b0, sfx_trigger = 1'b0, audio_out_allowed = 1'b0;
  logic [1:0]         sfx_id = 2'd0;
  logic [31:0]        left_out, right_out, left2, right2;
  logic               write_out, busy, write2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sfx_mixer #(
    .TICK_DIV(TICK), .SFX_AMP(10'sd200),
    .HP_MOVE(6), .HP_PUSH(7), .HP_WIN(8), .HP_FAIL(9),
    .MS_MOVE(4), .MS_PUSH(80), .MS_WIN(40), .MS_FAIL(20)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .bgm_left(bgm_left), .bgm_right(bgm_right), .bgm_valid(bgm_valid),
    .sfx_trigger(sfx_trigger), .sfx_id(sfx_id), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
    .write_audio_out(write_out), .sfx_busy(busy)
  );

  sfx_mixer #(
    .TICK_DIV(TICK), .SFX_AMP(10'sd400),
    .HP_MOVE(6), .HP_PUSH(7), .HP_WIN(8), .HP_FAIL(9),
    .MS_MOVE(4), .MS_PUSH(80), .MS_WIN(40), .MS_FAIL(20)
  ) dut_loud (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .bgm_left(bgm_left), .bgm_right(bgm_right), .bgm_valid(bgm_valid),
    .sfx_trigger(sfx_trigger), .sfx_id(sfx_id), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left2), .right_channel_audio_out(right2),
    .write_audio_out(write2), .sfx_busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [31:0] s32(input logic signed [9:0] v);
    return {v, 22'd0};
  endfunction

  // Number of phase toggles after m edges of an effect; sw > 0 halves the period from edge sw.
  function automatic int toggles(input int m, input int hp, input int sw);
    if (sw == 0 || m < sw) return m / hp;
    return sw / hp + (m - sw) / (hp / 2);
  endfunction

  // Plays an effect over silent bgm so the outputs carry the bare square wave.
  task automatic play(input logic [1:0] id, input int dur, input int hp, input int sw,
                      input string tag);
    int busy_cnt, bad;
    logic [31:0] exp;
    sfx_id = id; sfx_trigger = 1'b1;
    bgm_left = '0; bgm_right = '0; bgm_valid = 1'b1; audio_out_allowed = 1'b1;
    step();
    sfx_trigger = 1'b0;
    busy_cnt = busy ? 1 : 0;
    bad = 0;
    for (int n = 1; n <= dur + 5; n++) begin
      step();
      if (busy) busy_cnt++;
      if (n <= dur) exp = (toggles(n - 1, hp, sw) % 2 == 1) ? s32(10'sd200) : s32(-10'sd200);
      else          exp = 32'd0;
      if (left_out !== exp || right_out !== exp) bad++;
    end
    bgm_valid = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(dur));
    check({tag, "_wave_bad_samples"}, 32'(bad), 32'd0);
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_left", left_out, 32'd0);
    check("rst_right", right_out, 32'd0);
    check("rst_write", {31'd0, write_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    step();

    // Idle mix: no ducking, no sfx, one write pulse
    bgm_left = 10'sd100; bgm_right = -10'sd50; bgm_valid = 1'b1; audio_out_allowed = 1'b1;
    step();
    bgm_valid = 1'b0;
    check("idle_left", left_out, s32(10'sd100));
    check("idle_right", right_out, s32(-10'sd50));
    check("idle_write", {31'd0, write_out}, 32'd1);
    step();
    check("idle_write_once", {31'd0, write_out}, 32'd0);
    check("idle_hold", left_out, s32(10'sd100));

    // Backpressure: three samples queued onto one output, latest wins
    audio_out_allowed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bgm_left = 10'(10 * (i + 1)); bgm_right = -10'(10 * (i + 1)); bgm_valid = 1'b1;
      step();
      check("bp_no_write", {31'd0, write_out}, 32'd0);
    end
    bgm_valid = 1'b0;
    check("bp_left", left_out, s32(10'sd30));
    check("bp_right", right_out, s32(-10'sd30));
    step(3);
    check("bp_still_no_write", {31'd0, write_out}, 32'd0);
    audio_out_allowed = 1'b1;
    #1;
    check("bp_release_write", {31'd0, write_out}, 32'd1);
    step();
    check("bp_single_write", {31'd0, write_out}, 32'd0);

    // New sample in the same cycle as the strobe keeps pending set
    bgm_left = 10'sd40; bgm_right = 10'sd40; bgm_valid = 1'b1;
    step();
    check("same_write", {31'd0, write_out}, 32'd1);
    bgm_left = 10'sd50;
    step();
    bgm_valid = 1'b0;
    check("same_left_new", left_out, s32(10'sd50));
    check("same_pending_kept", {31'd0, write_out}, 32'd1);
    step();
    check("same_drained", {31'd0, write_out}, 32'd0);

    // Saturation and ducking with the move effect (half-period 6)
    sfx_id = 2'd0; sfx_trigger = 1'b1;
    step();
    sfx_trigger = 1'b0;
    check("move_busy", {31'd0, busy}, 32'd1);
    step(6);
    bgm_left = 10'sd511; bgm_right = -10'sd512; bgm_valid = 1'b1;
    step();
    bgm_valid = 1'b0;
    check("sat_pos_left", left_out, s32(10'sd455));
    check("sat_pos_right", right_out, s32(-10'sd56));
    check("sat_pos_left_loud", left2, s32(10'sd511));
    check("sat_pos_right_loud", right2, s32(10'sd144));
    step(5);
    bgm_left = -10'sd512; bgm_right = 10'sd511; bgm_valid = 1'b1;
    step();
    bgm_valid = 1'b0;
    check("sat_neg_left", left_out, s32(-10'sd456));
    check("sat_neg_right", right_out, s32(10'sd55));
    check("sat_neg_left_loud", left2, s32(-10'sd512));
    check("sat_neg_right_loud", right2, s32(-10'sd145));
    step(40);
    check("move_done", {31'd0, busy}, 32'd0);

    // Durations and tone periods
    play(2'd1, 800, 7, 0, "push");
    play(2'd2, 400, 8, 200, "win");

    // Retrigger: fail, then move 10 ms later restarts timing and phase
    sfx_id = 2'd3; sfx_trigger = 1'b1;
    step();
    sfx_trigger = 1'b0;
    step(99);
    check("fail_busy", {31'd0, busy}, 32'd1);
    play(2'd0, 40, 6, 0, "retrig");

    // Reset mid-effect aborts asynchronously, triggers ignored while held
    sfx_id = 2'd1; sfx_trigger = 1'b1;
    step();
    sfx_trigger = 1'b0;
    bgm_left = 10'sd100; bgm_right = 10'sd100; bgm_valid = 1'b1;
    step(20);
    bgm_valid = 1'b0;
    check("pre_rst_left", left_out, s32(-10'sd150));
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_left", left_out, 32'd0);
    check("arst_right", right_out, 32'd0);
    check("arst_write", {31'd0, write_out}, 32'd0);
    sfx_trigger = 1'b1;
    step(2);
    sfx_trigger = 1'b0;
    check("rst_trigger_ignored", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    step(3);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_no_write", {31'd0, write_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
